// File: rtl/register_transfer_sequencer.sv
// Sequences bus-mux selects and register load enables for MOVE, ALU and MULDIV
// register transfers. All outputs are registered alongside the state.
module register_transfer_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [4:0]  cmd_src_a,
  input  logic [4:0]  cmd_src_b,
  input  logic [4:0]  cmd_dst,
  input  logic [4:0]  cmd_alu_op,
  output logic [4:0]  select_signal,
  output logic [15:0] r_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        pc_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] MODE_MOVE   = 2'd0;
  localparam logic [1:0] MODE_ALU    = 2'd1;
  localparam logic [1:0] MODE_MULDIV = 2'd2;
  localparam logic [4:0] SEL_IDLE    = 5'd31;
  localparam logic [4:0] SEL_Z_HIGH  = 5'd18;
  localparam logic [4:0] SEL_Z_LOW   = 5'd19;

  typedef enum logic [2:0] {IDLE, S_A, S_B, S_LO, S_HI, ERR} state_t;

  state_t     state;
  logic [1:0] mode_q;
  logic [4:0] src_b_q;
  logic [4:0] dst_q;
  logic [4:0] op_q;

  function automatic logic cmd_legal(input logic [1:0] mode, input logic [4:0] src_a,
                                     input logic [4:0] src_b, input logic [4:0] dst);
    logic ok;
    ok = 1'b1;
    if (mode == 2'd3) ok = 1'b0;
    if (src_a > 5'd22) ok = 1'b0;
    if (mode != MODE_MOVE && src_b > 5'd22) ok = 1'b0;
    if (mode != MODE_MULDIV && !(dst <= 5'd17 || dst == 5'd20 || dst == 5'd21)) ok = 1'b0;
    return ok;
  endfunction

  // Packed as {mdr, pc, lo, hi, r[15:0]}
  function automatic logic [19:0] dst_en(input logic [4:0] d);
    logic [19:0] e;
    e = '0;
    if (d < 5'd16)       e[d[3:0]] = 1'b1;
    else if (d == 5'd16) e[16] = 1'b1;
    else if (d == 5'd17) e[17] = 1'b1;
    else if (d == 5'd20) e[18] = 1'b1;
    else if (d == 5'd21) e[19] = 1'b1;
    return e;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      select_signal <= SEL_IDLE;
      r_in          <= '0;
      hi_in         <= 1'b0;
      lo_in         <= 1'b0;
      pc_in         <= 1'b0;
      mdr_in        <= 1'b0;
      y_in          <= 1'b0;
      z_in          <= 1'b0;
      alu_op        <= '0;
      mode_q        <= '0;
      src_b_q       <= '0;
      dst_q         <= '0;
      op_q          <= '0;
    end else begin
      // Every step is a single-cycle strobe; defaults return the bus to idle.
      select_signal <= SEL_IDLE;
      r_in          <= '0;
      hi_in         <= 1'b0;
      lo_in         <= 1'b0;
      pc_in         <= 1'b0;
      mdr_in        <= 1'b0;
      y_in          <= 1'b0;
      z_in          <= 1'b0;
      alu_op        <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            mode_q    <= cmd_mode;
            src_b_q   <= cmd_src_b;
            dst_q     <= cmd_dst;
            op_q      <= cmd_alu_op;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (!cmd_legal(cmd_mode, cmd_src_a, cmd_src_b, cmd_dst)) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (cmd_mode == MODE_MOVE) begin
              state         <= S_LO;
              select_signal <= cmd_src_a;
              {mdr_in, pc_in, lo_in, hi_in, r_in} <= dst_en(cmd_dst);
              done          <= 1'b1;
            end else begin
              state         <= S_A;
              select_signal <= cmd_src_a;
              y_in          <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        S_A: begin
          state         <= S_B;
          select_signal <= src_b_q;
          alu_op        <= op_q;
          z_in          <= 1'b1;
        end
        S_B: begin
          state         <= S_LO;
          select_signal <= SEL_Z_LOW;
          if (mode_q == MODE_ALU) begin
            {mdr_in, pc_in, lo_in, hi_in, r_in} <= dst_en(dst_q);
            done <= 1'b1;
          end else begin
            lo_in <= 1'b1;
          end
        end
        S_LO: begin
          if (mode_q == MODE_MULDIV) begin
            state         <= S_HI;
            select_signal <= SEL_Z_HIGH;
            hi_in         <= 1'b1;
            done          <= 1'b1;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Scoreboard bench for register_transfer_sequencer: directed commands push
// hand-computed per-cycle outputs; a negedge monitor pops and compares them.
module tb_register_transfer_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0;
  logic [4:0]  cmd_src_a = '0;
  logic [4:0]  cmd_src_b = '0;
  logic [4:0]  cmd_dst = '0;
  logic [4:0]  cmd_alu_op = '0;
  logic [4:0]  select_signal;
  logic [15:0] r_in;
  logic        hi_in, lo_in, pc_in, mdr_in, y_in, z_in;
  logic [4:0]  alu_op;
  logic        busy, done, err;

  register_transfer_sequencer dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_alu_op(cmd_alu_op), .select_signal(select_signal),
    .r_in(r_in), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .mdr_in(mdr_in),
    .y_in(y_in), .z_in(z_in), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Enable bit patterns in {hi, lo, pc, mdr, y, z} order
  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_HI   = 6'b100000;
  localparam logic [5:0] EN_LO   = 6'b010000;
  localparam logic [5:0] EN_PC   = 6'b001000;
  localparam logic [5:0] EN_MDR  = 6'b000100;
  localparam logic [5:0] EN_Y    = 6'b000010;
  localparam logic [5:0] EN_Z    = 6'b000001;
  localparam logic [33:0] IDLE_VEC = {5'd31, 29'd0};

  typedef struct {
    int          cyc;
    logic [33:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [33:0] mk(input logic [4:0] sel, input logic [15:0] r,
                                     input logic [5:0] en, input logic [4:0] op,
                                     input logic dn, input logic er);
    return {sel, r, en, op, dn, er};
  endfunction

  function automatic logic [33:0] dut_vec();
    return {select_signal, r_in, hi_in, lo_in, pc_in, mdr_in, y_in, z_in, alu_op, done, err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input string name, input int c, input logic [33:0] v);
    exp_t e;
    e.cyc = c;
    e.v = v;
    e.name = name;
    q.push_back(e);
  endtask

  // Offers a command and returns the cycle index of its accept edge; leaves cmd_valid high.
  task automatic send(input logic [1:0] mode, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [4:0] op, output int acc);
    logic r;
    bit   ok;
    cmd_mode = mode; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_alu_op = op;
    cmd_valid = 1'b1;
    ok = 1'b0;
    acc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      r = cmd_ready;
      @(posedge clock);
      #1;
      if (r) ok = 1'b1;
    end
    if (ok) begin
      acc = cyc;
      check("busy_after_accept", {63'd0, busy}, 64'd1);
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  always @(negedge clock) begin : monitor
    logic [33:0] v;
    exp_t        e;
    v = dut_vec();
    if (clear === 1'b1 && v !== IDLE_VEC) begin
      check("one_hot_enables",
            {63'd0, ($countones({r_in, hi_in, lo_in, pc_in, mdr_in, y_in, z_in}) <= 1)}, 64'd1);
      if (q.size() == 0) begin
        check("unexpected_output", {30'd0, v}, {30'd0, IDLE_VEC});
      end else begin
        e = q.pop_front();
        check({e.name, "_vec"}, {30'd0, v}, {30'd0, e.v});
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    int a, a2;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_vec", {30'd0, dut_vec()}, {30'd0, IDLE_VEC});
    check("reset_busy_ready", {62'd0, busy, cmd_ready}, 64'd0);
    @(negedge clock) clear = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_release", {63'd0, cmd_ready}, 64'd1);

    // MOVE MDR -> R3
    send(2'd0, 5'd21, 5'd0, 5'd3, 5'd0, a);
    push("move_r3", a, mk(5'd21, 16'h0008, EN_NONE, 5'd0, 1'b1, 1'b0));
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    check("move_then_idle", {30'd0, dut_vec(), busy}, {30'd0, IDLE_VEC, 1'b0});

    // ALU R1 op R2 -> R5
    send(2'd1, 5'd1, 5'd2, 5'd5, 5'd3, a);
    push("alu_y", a,     mk(5'd1,  16'h0000, EN_Y, 5'd0, 1'b0, 1'b0));
    push("alu_z", a + 1, mk(5'd2,  16'h0000, EN_Z, 5'd3, 1'b0, 1'b0));
    push("alu_w", a + 2, mk(5'd19, 16'h0020, EN_NONE, 5'd0, 1'b1, 1'b0));
    cmd_valid = 1'b0;

    // MULDIV R4, R6 (dst ignored even if out of range)
    send(2'd2, 5'd4, 5'd6, 5'd31, 5'd7, a);
    push("md_y",  a,     mk(5'd4,  16'h0000, EN_Y,  5'd0, 1'b0, 1'b0));
    push("md_z",  a + 1, mk(5'd6,  16'h0000, EN_Z,  5'd7, 1'b0, 1'b0));
    push("md_lo", a + 2, mk(5'd19, 16'h0000, EN_LO, 5'd0, 1'b0, 1'b0));
    push("md_hi", a + 3, mk(5'd18, 16'h0000, EN_HI, 5'd0, 1'b1, 1'b0));
    cmd_valid = 1'b0;

    // Special destinations; MOVE ignores an out-of-range src_b
    send(2'd0, 5'd20, 5'd31, 5'd20, 5'd0, a);
    push("move_pc", a, mk(5'd20, 16'h0000, EN_PC, 5'd0, 1'b1, 1'b0));
    send(2'd0, 5'd22, 5'd0, 5'd21, 5'd0, a);
    push("move_mdr", a, mk(5'd22, 16'h0000, EN_MDR, 5'd0, 1'b1, 1'b0));
    send(2'd0, 5'd16, 5'd0, 5'd17, 5'd0, a);
    push("move_lo", a, mk(5'd16, 16'h0000, EN_LO, 5'd0, 1'b1, 1'b0));
    send(2'd0, 5'd15, 5'd0, 5'd15, 5'd0, a);
    push("move_r15", a, mk(5'd15, 16'h8000, EN_NONE, 5'd0, 1'b1, 1'b0));
    cmd_valid = 1'b0;

    // Illegal commands
    send(2'd3, 5'd1, 5'd1, 5'd1, 5'd0, a);
    push("err_mode3", a, mk(5'd31, 16'h0000, EN_NONE, 5'd0, 1'b0, 1'b1));
    send(2'd1, 5'd25, 5'd1, 5'd1, 5'd0, a);
    push("err_src_a", a, mk(5'd31, 16'h0000, EN_NONE, 5'd0, 1'b0, 1'b1));
    send(2'd0, 5'd1, 5'd0, 5'd19, 5'd0, a);
    push("err_dst19", a, mk(5'd31, 16'h0000, EN_NONE, 5'd0, 1'b0, 1'b1));
    send(2'd1, 5'd1, 5'd23, 5'd2, 5'd0, a);
    push("err_src_b", a, mk(5'd31, 16'h0000, EN_NONE, 5'd0, 1'b0, 1'b1));
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    check("err_then_idle", {30'd0, dut_vec(), busy}, {30'd0, IDLE_VEC, 1'b0});

    // Reset asserted mid-S_B
    send(2'd1, 5'd7, 5'd8, 5'd9, 5'd4, a);
    push("rst_y", a,     mk(5'd7, 16'h0000, EN_Y, 5'd0, 1'b0, 1'b0));
    push("rst_z", a + 1, mk(5'd8, 16'h0000, EN_Z, 5'd4, 1'b0, 1'b0));
    cmd_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
    clear = 1'b0;
    #1;
    check("midrst_vec", {30'd0, dut_vec()}, {30'd0, IDLE_VEC});
    check("midrst_busy_ready", {62'd0, busy, cmd_ready}, 64'd0);
    @(negedge clock) clear = 1'b1;
    @(posedge clock);
    #1;
    send(2'd0, 5'd5, 5'd0, 5'd0, 5'd0, a);
    push("post_rst_move", a, mk(5'd5, 16'h0001, EN_NONE, 5'd0, 1'b1, 1'b0));

    // cmd_valid held across two commands
    send(2'd0, 5'd0, 5'd0, 5'd1, 5'd0, a);
    push("b2b_first", a, mk(5'd0, 16'h0002, EN_NONE, 5'd0, 1'b1, 1'b0));
    send(2'd0, 5'd17, 5'd0, 5'd16, 5'd0, a2);
    push("b2b_second", a2, mk(5'd17, 16'h0000, EN_HI, 5'd0, 1'b1, 1'b0));
    cmd_valid = 1'b0;
    check("b2b_gap", a2 - a, 2);

    repeat (4) @(posedge clock);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_transfer_sequencer.md
REGISTER_TRANSFER_SEQUENCER -- requirements
Module: register_transfer_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  rising-edge system clock.
REQ-002 SHALL have port: clear  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: cmd_valid  in  1  command offered.
REQ-004 SHALL have port: cmd_ready  out  1  sequencer can accept a command.
REQ-005 SHALL have port: cmd_mode  in  2  0 MOVE, 1 ALU, 2 MULDIV, 3 reserved.
REQ-006 SHALL have port: cmd_src_a  in  5  first bus source, using the bus-mux select code (0-15 R0-R15, 16 HI, 17 LO, 18 Z_high, 19 Z_low, 20 PC, 21 MDR, 22 InPort).
REQ-007 SHALL have port: cmd_src_b  in  5  second bus source, same code; ignored in MOVE.
REQ-008 SHALL have port: cmd_dst  in  5  destination: 0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR; ignored in MULDIV.
REQ-009 SHALL have port: cmd_alu_op  in  5  ALU opcode passed through to the ALU.
REQ-010 SHALL have port: select_signal  out  5  bus-mux select.
REQ-011 SHALL have port: r_in  out  16  one-hot GPR load enables, bit n = Rn.
REQ-012 SHALL have port: hi_in, lo_in, pc_in, mdr_in, y_in, z_in  out  1 each  load enables.
REQ-013 SHALL have port: alu_op  out  5  opcode to the ALU.
REQ-014 SHALL have port: busy  out  1  command in progress.
REQ-015 SHALL have port: done  out  1  one-cycle pulse on the final step.
REQ-016 SHALL have port: err  out  1  one-cycle pulse on rejected command.

Function
REQ-017 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1, latching all cmd_* fields; cmd_ready=1 only in IDLE.
REQ-018 SHALL implement states IDLE, S_A, S_B, S_LO, S_HI, ERR; every output decoded from the state and latched fields only, no combinational path from cmd_*.
REQ-019 SHALL check legality at acceptance: mode 3, src_a>22, src_b>22 (ALU/MULDIV), or dst outside {0-17,20,21} (MOVE/ALU) -> ERR.
REQ-020 SHALL in IDLE and ERR drive select_signal=31 (mux default, bus=0), all load enables 0, alu_op=0.
REQ-021 SHALL in MOVE: IDLE -> S_LO (select=src_a, dst enable=1, done=1) -> IDLE.
REQ-022 SHALL in ALU: IDLE -> S_A (select=src_a, y_in=1) -> S_B (select=src_b, alu_op=latched op, z_in=1) -> S_LO (select=19, dst enable=1, done=1) -> IDLE.
REQ-023 SHALL in MULDIV: S_A -> S_B as ALU -> S_LO (select=19, lo_in=1) -> S_HI (select=18, hi_in=1, done=1) -> IDLE.
REQ-024 SHALL hold alu_op at the latched opcode in S_B only, 0 elsewhere.
REQ-025 SHALL assert at most one of r_in/hi_in/lo_in/pc_in/mdr_in/y_in/z_in in any cycle.
REQ-026 SHALL in ERR assert err=1 for exactly one cycle, no load enable, then return to IDLE.
REQ-027 SHALL assert busy=1 in every state except IDLE.
REQ-028 SHALL ignore cmd_valid while not IDLE; a held cmd_valid is accepted on the first IDLE edge, giving one IDLE cycle between back-to-back commands.
REQ-029 SHALL produce latency from accept edge to done: MOVE 1, ALU 3, MULDIV 4 cycles.

Reset
REQ-030 SHALL on clear=0 immediately enter IDLE, abandoning any command: select_signal=31, all enables 0, alu_op=0, busy=0, done=0, err=0, cmd_ready=0.
REQ-031 SHALL hold cmd_ready=1 from the first rising edge after clear deasserts.

Verification
REQ-032 SHALL verify MOVE src=21 dst=3 -> next cycle select=21, r_in=0x0008, done=1; then IDLE, select=31.
REQ-033 SHALL verify ALU src_a=1 src_b=2 dst=5 op=3 -> y_in@select=1, z_in@select=2 alu_op=3, r_in=0x0020@select=19 with done.
REQ-034 SHALL verify MULDIV src_a=4 src_b=6 -> y_in, z_in, lo_in@19, hi_in@18 with done on 4th cycle.
REQ-035 SHALL verify illegal cmds (mode=3; src_a=25; MOVE dst=19) -> single err pulse, zero load enables.
REQ-036 SHALL verify clear=0 asserted mid-S_B -> all enables 0 at once, busy=0; after release a new MOVE completes normally.
REQ-037 SHALL verify cmd_valid held high across two commands -> second accepted one IDLE cycle after first done.
